// File: rtl/keccak_round_sequencer.sv
// Keccak permutation control sequencer: reset clear, absorb lane selects, lambda/chi round stepping.
// Latency: W clear cycles after reset, then ROUNDS*(1+CHI_CYC) cycles from start to DonexSO.
// Backpressure: AbsorbReadyxSO low outside IDLE/ABSORB; optional chi stall via KECCAK_SEQ_RAND_STALL_EN.
module keccak_round_sequencer #(
    parameter int W            = 16,
    parameter int RATE         = 128,
    parameter int ABSORB_LANES = 2,
    parameter int CHI_SLICES   = 1
) (
    input  logic                             ClkxCI,
    input  logic                             RstxRI,
    input  logic                             AbsorbValidxSI,
    output logic                             AbsorbReadyxSO,
    input  logic                             StartPermxSI,
    input  logic [4:0]                       NumRoundsxDI,
    input  logic                             RandomnessAvailablexSI,
    output logic                             EnResetStatexSO,
    output logic [24:0]                      AbsorbLaneSelxDO,
    output logic                             EnLambdaxSO,
    output logic                             EnChiIotaxSO,
    output logic [4:0]                       RoundNrxDO,
    output logic [$clog2(W/CHI_SLICES):0]    SliceCntxDO,
    output logic                             ReadyxSO,
    output logic                             DonexSO
);

    localparam int ROUNDS_MAX = 12 + 2 * $clog2(W);
    localparam int BEATS      = RATE / (W * ABSORB_LANES);
    localparam int CHI_CYC    = W / CHI_SLICES;
    localparam int SW         = $clog2(CHI_CYC) + 1;
    localparam int RW         = $clog2(W) + 1;
    localparam int BW         = $clog2(BEATS) + 1;

    typedef enum logic [2:0] {
        S_RESET,
        S_IDLE,
        S_ABSORB,
        S_LAMBDA,
        S_CHI
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [SW-1:0]   slice_q, slice_d;
    logic [4:0]      round_q, round_d;
    logic            done_q, done_d;

    logic            absorb_rdy;
    logic            beat_fire;
    logic            chi_adv;
    logic            launch;
    logic [4:0]      n_clamp;
    logic [24:0]     lane_mask;

`ifdef KECCAK_SEQ_RAND_STALL_EN
    assign chi_adv = RandomnessAvailablexSI;
`else
    logic unused_rand;
    assign unused_rand = RandomnessAvailablexSI;
    assign chi_adv     = 1'b1;
`endif

    assign absorb_rdy = (state_q == S_IDLE) || (state_q == S_ABSORB);
    assign beat_fire  = AbsorbValidxSI && absorb_rdy;
    assign n_clamp    = (NumRoundsxDI == 5'd0 || NumRoundsxDI > 5'(ROUNDS_MAX))
                        ? 5'(ROUNDS_MAX) : NumRoundsxDI;

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < 25; i++) begin
            if (i / ABSORB_LANES == int'(beat_q)) lane_mask[i] = 1'b1;
        end
    end

    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            state_q   <= S_RESET;
            rst_cnt_q <= '0;
            beat_q    <= '0;
            slice_q   <= '0;
            round_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            beat_q    <= beat_d;
            slice_q   <= slice_d;
            round_q   <= round_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        rst_cnt_d        = rst_cnt_q;
        beat_d           = beat_q;
        slice_d          = slice_q;
        round_d          = round_q;
        done_d           = 1'b0;
        launch           = 1'b0;
        EnResetStatexSO  = 1'b0;
        AbsorbLaneSelxDO = '0;
        EnLambdaxSO      = 1'b0;
        EnChiIotaxSO     = 1'b0;
        ReadyxSO         = 1'b0;

        case (state_q)
            S_RESET: begin
                EnResetStatexSO  = 1'b1;
                AbsorbLaneSelxDO = '1;
                if (rst_cnt_q == RW'(W - 1)) begin
                    rst_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                ReadyxSO = 1'b1;
                // Absorb has priority over a bare permutation start.
                if (beat_fire) begin
                    AbsorbLaneSelxDO = lane_mask;
                    if (BEATS == 1) begin
                        launch = 1'b1;
                    end else begin
                        beat_d  = BW'(1);
                        state_d = S_ABSORB;
                    end
                end else if (StartPermxSI) begin
                    launch = 1'b1;
                end
            end
            S_ABSORB: begin
                if (beat_fire) begin
                    AbsorbLaneSelxDO = lane_mask;
                    if (beat_q == BW'(BEATS - 1)) begin
                        beat_d = '0;
                        launch = 1'b1;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_LAMBDA: begin
                EnLambdaxSO      = 1'b1;
                AbsorbLaneSelxDO = '1;
                slice_d          = '0;
                state_d          = S_CHI;
            end
            S_CHI: begin
                if (chi_adv) begin
                    EnChiIotaxSO     = 1'b1;
                    AbsorbLaneSelxDO = '1;
                    if (slice_q == SW'(CHI_CYC - 1)) begin
                        slice_d = '0;
                        if (round_q == 5'(ROUNDS_MAX - 1)) begin
                            round_d = '0;
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            round_d = round_q + 5'd1;
                            state_d = S_LAMBDA;
                        end
                    end else begin
                        slice_d = slice_q + 1'b1;
                    end
                end
            end
            default: state_d = S_RESET;
        endcase

        // The requested round count lives on as the starting round offset.
        if (launch) begin
            round_d = 5'(ROUNDS_MAX) - n_clamp;
            state_d = S_LAMBDA;
        end
    end

    assign AbsorbReadyxSO = absorb_rdy;
    assign RoundNrxDO     = round_q;
    assign SliceCntxDO    = slice_q;
    assign DonexSO        = done_q;

endmodule

// File: tb/tb_keccak_round_sequencer.sv
// Bench for keccak_round_sequencer: vector table, hand sequences for reset cases, randomized runs vs a round/latency model.
module tb_keccak_round_sequencer;

    localparam int W     = 16;
    localparam int RM    = 20;
    localparam int BEATS = 4;
    localparam int AL    = 2;
    localparam int CHI   = 16;
`ifdef KECCAK_SEQ_RAND_STALL_EN
    localparam int STALL_EXTRA = 5;
`else
    localparam int STALL_EXTRA = 0;
`endif

    logic        clk;
    logic        rst;
    logic        av;
    logic        ar;
    logic        sp;
    logic [4:0]  nr;
    logic        rnd;
    logic        ers;
    logic [24:0] sel;
    logic        el;
    logic        ec;
    logic [4:0]  rn;
    logic [4:0]  sc;
    logic        rdy;
    logic        done;

    int n_pass;
    int n_total;

    keccak_round_sequencer #(
        .W(W), .RATE(128), .ABSORB_LANES(AL), .CHI_SLICES(1)
    ) dut (
        .ClkxCI(clk),
        .RstxRI(rst),
        .AbsorbValidxSI(av),
        .AbsorbReadyxSO(ar),
        .StartPermxSI(sp),
        .NumRoundsxDI(nr),
        .RandomnessAvailablexSI(rnd),
        .EnResetStatexSO(ers),
        .AbsorbLaneSelxDO(sel),
        .EnLambdaxSO(el),
        .EnChiIotaxSO(ec),
        .RoundNrxDO(rn),
        .SliceCntxDO(sc),
        .ReadyxSO(rdy),
        .DonexSO(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    function automatic logic [24:0] beat_mask(input int b);
        logic [24:0] m;
        m = '0;
        for (int i = 0; i < AL; i++) m[b * AL + i] = 1'b1;
        return m;
    endfunction

    function automatic int model_rounds(input int n);
        return (n == 0 || n > RM) ? RM : n;
    endfunction

    task automatic do_reset(input int hold);
        int cnt;
        int bad_done;
        cnt = 0;
        bad_done = 0;
        @(posedge clk); #1;
        rst = 1'b1; av = 1'b0; sp = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #2;
            chk("rst_en_reset_state", ers, 1);
            chk("rst_ready", rdy, 0);
            chk("rst_absorb_ready", ar, 0);
            chk("rst_done", done, 0);
            chk("rst_round_nr", rn, 0);
            chk("rst_slice_cnt", sc, 0);
            chk("rst_en_lambda", el, 0);
            chk("rst_en_chi", ec, 0);
            chk("rst_lane_sel", sel, 25'h1FFFFFF);
        end
        rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (ers) cnt++;
            if (done) bad_done++;
            if (rdy) break;
            @(posedge clk); #2;
        end
        chk("reset_clear_cycles", cnt, W);
        chk("reset_then_ready", rdy, 1);
        chk("reset_then_absorb_ready", ar, 1);
        chk("reset_no_done", bad_done, 0);
    endtask

    task automatic perm(input string name, input int n, input bit absorb, input int gap_beat,
                        input int gap_len, input bit rand_gaps, input bit noise,
                        input int stall_round, input int first_exp, input int lat_exp);
        int gap;
        int lat;
        int lambdas;
        int chi_in;
        int chi_total;
        int stall_left;
        int rounds_exp;
        bit stalling;
        lat = -1; lambdas = 0; chi_in = 0; chi_total = 0; stall_left = 0;
        stalling = 1'b0;
        rounds_exp = RM - first_exp;
        @(posedge clk); #1;
        nr = 5'(n);
        rnd = 1'b1;
        if (absorb) begin
            for (int b = 0; b < BEATS; b++) begin
                gap = rand_gaps ? int'($urandom_range(0, 2)) : ((b == gap_beat) ? gap_len : 0);
                for (int g = 0; g < gap; g++) begin
                    av = 1'b0;
                    sp = (noise && b > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                    #1;
                    chk({name, "_gap_lane_sel"}, sel, 0);
                    chk({name, "_gap_absorb_ready"}, ar, 1);
                    @(posedge clk); #1;
                end
                av = 1'b1;
                sp = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                #1;
                chk({name, "_beat_lane_sel"}, sel, int'(beat_mask(b)));
                chk({name, "_beat_absorb_ready"}, ar, 1);
                @(posedge clk); #1;
            end
            av = 1'b0; sp = 1'b0;
        end else begin
            av = 1'b0; sp = 1'b1;
            #1;
            chk({name, "_start_ready"}, rdy, 1);
            @(posedge clk); #1;
            sp = 1'b0;
        end
        for (int c = 0; c <= 3000; c++) begin
            if (noise && c < lat_exp) begin
                av = 1'($urandom_range(0, 1));
                sp = 1'($urandom_range(0, 1));
                nr = 5'($urandom_range(0, 31));
            end else begin
                av = 1'b0; sp = 1'b0;
            end
            stalling = (stall_left > 0);
            rnd = !stalling;
            if (stall_left > 0) stall_left--;
            #1;
            if (done) begin
                lat = c;
                break;
            end
            chk({name, "_busy_absorb_ready"}, ar, 0);
            chk({name, "_busy_ready"}, rdy, 0);
            if (el) begin
                chk({name, "_lambda_round"}, rn, first_exp + lambdas);
                chk({name, "_lambda_lane_sel"}, sel, 25'h1FFFFFF);
                lambdas++;
                chi_in = 0;
`ifdef KECCAK_SEQ_RAND_STALL_EN
            end else if (stalling) begin
                chk({name, "_stall_en_chi"}, ec, 0);
                chk({name, "_stall_slice_frozen"}, sc, chi_in);
                chk({name, "_stall_round"}, rn, first_exp + lambdas - 1);
`endif
            end else begin
                chk({name, "_chi_en"}, ec, 1);
                chk({name, "_chi_slice"}, sc, chi_in);
                chk({name, "_chi_round"}, rn, first_exp + lambdas - 1);
                if (rn == 5'(stall_round) && chi_in == 0) stall_left = 5;
                chi_in++;
                chi_total++;
            end
            @(posedge clk); #1;
        end
        chk({name, "_done_latency"}, lat, lat_exp);
        chk({name, "_round_count"}, lambdas, rounds_exp);
        chk({name, "_chi_count"}, chi_total, rounds_exp * CHI);
        chk({name, "_done_round_nr"}, rn, 0);
        chk({name, "_done_ready"}, rdy, 1);
        av = 1'b0; sp = 1'b0; rnd = 1'b1;
        @(posedge clk); #2;
        chk({name, "_done_pulse_width"}, done, 0);
    endtask

    typedef struct {
        int n;
        bit absorb;
        int gap_beat;
        int gap_len;
        int stall_round;
        int first_exp;
        int lat_exp;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int r;
        int nn;
        n_pass = 0; n_total = 0;
        rst = 1'b1; av = 1'b0; sp = 1'b0; nr = 5'd0; rnd = 1'b1;

        tbl[0] = '{n: 20, absorb: 1'b1, gap_beat: -1, gap_len: 0, stall_round: -1, first_exp: 0,  lat_exp: 340};
        tbl[1] = '{n: 12, absorb: 1'b0, gap_beat: -1, gap_len: 0, stall_round: -1, first_exp: 8,  lat_exp: 204};
        tbl[2] = '{n: 0,  absorb: 1'b0, gap_beat: -1, gap_len: 0, stall_round: -1, first_exp: 0,  lat_exp: 340};
        tbl[3] = '{n: 25, absorb: 1'b0, gap_beat: -1, gap_len: 0, stall_round: -1, first_exp: 0,  lat_exp: 340};
        tbl[4] = '{n: 20, absorb: 1'b1, gap_beat: 1,  gap_len: 3, stall_round: -1, first_exp: 0,  lat_exp: 340};
        tbl[5] = '{n: 1,  absorb: 1'b0, gap_beat: -1, gap_len: 0, stall_round: -1, first_exp: 19, lat_exp: 17};
        tbl[6] = '{n: 31, absorb: 1'b0, gap_beat: -1, gap_len: 0, stall_round: -1, first_exp: 0,  lat_exp: 340};
        tbl[7] = '{n: 20, absorb: 1'b1, gap_beat: -1, gap_len: 0, stall_round: 3,  first_exp: 0,  lat_exp: 340 + STALL_EXTRA};
        tbl[8] = '{n: 7,  absorb: 1'b1, gap_beat: 2,  gap_len: 1, stall_round: -1, first_exp: 13, lat_exp: 119};

        do_reset(3);

        for (int i = 0; i < 9; i++) begin
            perm($sformatf("vec%0d", i), tbl[i].n, tbl[i].absorb, tbl[i].gap_beat, tbl[i].gap_len,
                 1'b0, 1'b0, tbl[i].stall_round, tbl[i].first_exp, tbl[i].lat_exp);
        end

        for (int i = 0; i < 6; i++) begin
            nn = int'($urandom_range(0, 31));
            r  = model_rounds(nn);
            perm($sformatf("rand%0d", i), nn, 1'($urandom_range(0, 1)), -1, 0, 1'b1, 1'b1,
                 -1, RM - r, r * (1 + CHI));
        end

        // Reset landing in the middle of round 5 chi must abort without a done pulse.
        @(posedge clk); #1;
        nr = 5'd20; sp = 1'b1;
        @(posedge clk); #1;
        sp = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (rn == 5'd5 && ec) break;
            @(posedge clk); #1;
        end
        chk("mid_chi_reached_round5", int'(rn == 5'd5 && ec), 1);
        do_reset(1);
        perm("after_abort", 12, 1'b0, -1, 0, 1'b0, 1'b0, -1, 8, 204);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/keccak_round_sequencer.md
KECCAK_ROUND_SEQUENCER -- requirements
Module: keccak_round_sequencer

Interface
REQ-001 SHALL have parameter W, default 16: lane width, power of two, 1..64.
REQ-002 SHALL have parameter RATE, default 128: rate in bits, multiple of W*ABSORB_LANES, at most 25*W.
REQ-003 SHALL have parameter ABSORB_LANES, default 2: lanes accepted per absorb beat.
REQ-004 SHALL have parameter CHI_SLICES, default 1: slices per chi cycle, divides W.
REQ-005 SHALL have derived constants ROUNDS_MAX = 12+2*log2(W), BEATS = RATE/(W*ABSORB_LANES) and CHI_CYC = W/CHI_SLICES.
REQ-006 SHALL have ports:
- ClkxCI  in  1  clock, rising edge.
- RstxRI  in  1  synchronous, active-high reset.
- AbsorbValidxSI  in  1  absorb beat offered.
- AbsorbReadyxSO  out  1  absorb beat can be accepted.
- StartPermxSI  in  1  start permutation without absorb (squeeze).
- NumRoundsxDI  in  5  requested round count, sampled at start.
- RandomnessAvailablexSI  in  1  fresh masking randomness present.
- EnResetStatexSO  out  1  clear state.
- AbsorbLaneSelxDO  out  25  lane enables, bit index x+5*y.
- EnLambdaxSO  out  1  theta/rho/pi step.
- EnChiIotaxSO  out  1  chi/iota slice step.
- RoundNrxDO  out  5  current round index.
- SliceCntxDO  out  clog2(CHI_CYC)+1  chi cycle index.
- ReadyxSO  out  1  idle.
- DonexSO  out  1  one-cycle pulse, permutation finished.

Function
REQ-007 SHALL implement states RESET, IDLE, ABSORB, LAMBDA, CHI; all outputs SHALL be decoded from registered state and counters.
REQ-008 In RESET: EnResetStatexSO=1, AbsorbLaneSelxDO=all ones, W cycles, then IDLE.
REQ-009 In IDLE: ReadyxSO=1, AbsorbReadyxSO=1.
REQ-010 A beat transfers on AbsorbValidxSI & AbsorbReadyxSO; on beat b (0..BEATS-1), lanes b*ABSORB_LANES .. (b+1)*ABSORB_LANES-1 SHALL be set in AbsorbLaneSelxDO in that same cycle.
REQ-011 A beat accepted in IDLE moves the FSM to ABSORB (BEATS>1) or to LAMBDA (BEATS=1).
REQ-012 In ABSORB: AbsorbReadyxSO=1; the beat counter holds while AbsorbValidxSI=0; after beat BEATS-1 the FSM goes to LAMBDA.
REQ-013 StartPermxSI in IDLE with AbsorbValidxSI=0 SHALL go to LAMBDA; if both are high, absorb wins and StartPermxSI is ignored.
REQ-014 At permutation start, NumRoundsxDI SHALL be latched; 0 or >ROUNDS_MAX clamps to ROUNDS_MAX; RoundNr SHALL start at ROUNDS_MAX-N (Keccak-p reduced rounds).
REQ-015 LAMBDA SHALL last 1 cycle with EnLambdaxSO=1 and AbsorbLaneSelxDO=all ones, then go to CHI.
REQ-016 CHI SHALL last CHI_CYC advancing cycles; each advancing cycle asserts EnChiIotaxSO and AbsorbLaneSelxDO=all ones, and SliceCntxDO counts 0..CHI_CYC-1.
REQ-017 After the final CHI cycle: if RoundNr=ROUNDS_MAX-1, go to IDLE, pulse DonexSO in the first IDLE cycle and reset RoundNr to 0; otherwise increment RoundNr and go to LAMBDA.
REQ-018 AbsorbReadyxSO SHALL be 0 in LAMBDA and CHI; inputs offered then SHALL be ignored.

Reset
REQ-019 Any rising edge with RstxRI=1 SHALL force RESET and clear all counters, RoundNr and latched N, including mid-ABSORB/CHI.
REQ-020 While in RESET: ReadyxSO=0, AbsorbReadyxSO=0, DonexSO=0, EnLambdaxSO=0, EnChiIotaxSO=0, RoundNrxDO=0, SliceCntxDO=0.
REQ-021 The W-cycle clear count SHALL begin on the first edge with RstxRI=0.

Configuration
REQ-022 SHALL support macro KECCAK_SEQ_RAND_STALL_EN. When defined, a CHI cycle with RandomnessAvailablexSI=0 SHALL be non-advancing: EnChiIotaxSO=0, SliceCnt and RoundNr held. When undefined, RandomnessAvailablexSI SHALL be ignored.

Verification (W=16, RATE=128, ABSORB_LANES=2, CHI_SLICES=1: ROUNDS_MAX=20, BEATS=4, CHI_CYC=16)
REQ-023 Reset: RstxRI high 3 cycles, then low -> EnResetStatexSO high exactly 16 cycles after release, then ReadyxSO=1.
REQ-024 4 back-to-back beats, N=20 -> AbsorbLaneSelxDO 0x3, 0xC, 0x30, 0xC0; RoundNr 0..19; DonexSO exactly 340 cycles after the last beat.
REQ-025 StartPermxSI with N=12 -> first RoundNr=8, last RoundNr=19, DonexSO after 204 cycles; N=0 and N=25 each -> 20 rounds.
REQ-026 Valid gaps: beat 1 delayed 3 cycles -> lane select for beat 1 waits (0xC), no beat skipped.
REQ-027 RAND_STALL_EN defined, RandomnessAvailablexSI low 5 cycles in round 3 CHI -> SliceCnt frozen, DonexSO 5 cycles later (345); macro undefined -> still 340.
REQ-028 RstxRI pulse during round 5 CHI -> RESET, RoundNrxDO=0, no DonexSO, 16 clear cycles, then IDLE.
